// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter types: FSM state encoding and bit-period helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined (widens the encoding to 3 bits).
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: o_tick marks the last clock of each bit period.
// Cleared by the start pulse so the first bit of a frame is full length.
module uart_tx_baud_gen #(
  parameter int CYCLES_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clear || !i_run || (r_cnt == LAST))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start / LSB-first data / [even parity] / stop frame, registered outputs.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  output logic                    uart_tx_done
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(PAYLOAD_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  state_t                  r_state, w_state;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift;
  logic [BW-1:0]           r_bit_cnt, w_bit_cnt;
  logic                    r_stop_cnt, w_stop_cnt;
  logic                    r_txd, w_txd;
  logic                    r_busy, w_busy;
  logic                    r_done, w_done;
`ifdef UART_TX_PARITY_EN
  logic                    r_par, w_par;
`endif
  logic                    w_accept;
  logic                    w_tick;

  assign w_accept = (r_state == ST_IDLE) && uart_tx_en && !r_busy;

  uart_tx_baud_gen #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_accept),
    .i_run  (r_state != ST_IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_txd      <= w_txd;
      r_busy     <= w_busy;
      r_done     <= w_done;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par;
`endif
    end
  end

  // Every output is computed one edge early so txd/busy/done come straight from flops.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_txd      = r_txd;
    w_busy     = r_busy;
    w_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par      = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        w_txd  = 1'b1;
        w_busy = 1'b0;
        if (w_accept) begin
          w_state   = ST_START;
          w_shift   = uart_tx_data;
          w_bit_cnt = '0;
          w_txd     = 1'b0;
          w_busy    = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par     = ^uart_tx_data;
`endif
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state   = ST_DATA;
          w_txd     = r_shift[0];
          w_shift   = r_shift >> 1;
          w_bit_cnt = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state    = ST_PARITY;
            w_txd      = r_par;
`else
            w_state    = ST_STOP;
            w_txd      = 1'b1;
            w_stop_cnt = 1'b0;
`endif
          end else begin
            w_bit_cnt = r_bit_cnt + 1'b1;
            w_txd     = r_shift[0];
            w_shift   = r_shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state    = ST_STOP;
          w_txd      = 1'b1;
          w_stop_cnt = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop_cnt == LAST_STOP) begin
            w_state = ST_IDLE;
            w_txd   = 1'b1;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_stop_cnt = 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;
  assign uart_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a line-decoding scoreboard; small bit period (16 clocks).
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;

  localparam int CLK_HZ = 160;
  localparam int BIT_RATE = 10;
  localparam int CPB = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;
  localparam int LIMIT = 4 * FRAME;

  logic       clk;
  logic       rst;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_txd;
  logic       uart_tx_busy;
  logic       uart_tx_done;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  uart_tx #(
    .BIT_RATE    (BIT_RATE),
    .CLK_HZ      (CLK_HZ),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_txd    (uart_txd),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_done(uart_tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Raise en for the current cycle; returns 1ns after the accepting edge.
  task automatic accept_now(input logic [7:0] d);
    uart_tx_en   = 1'b1;
    uart_tx_data = d;
    exp_q.push_back(d);
    @(posedge clk); #1;
    uart_tx_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    accept_now(d);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (uart_tx_busy && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Line monitor: decode each frame against the model bit vector, sample every clock.
  initial begin
    logic       prev;
    logic [15:0] eb;
    logic [7:0] got;
    logic [7:0] d;
    int         mism;
    bit         abort_f;
    bit         have;
    prev = 1'b1;
    d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && uart_txd === 1'b0) begin
        have = (exp_q.size() > 0);
        chk("mon_expected_frame", {31'd0, have}, 32'd1);
        eb = '1; got = '0; mism = 0; abort_f = 1'b0;
        if (have) begin
          d = exp_q.pop_front();
          eb[0] = 1'b0;
          eb[8:1] = d;
`ifdef UART_TX_PARITY_EN
          eb[9] = ^d;
`endif
        end
        for (int j = 0; j < FRAME; j++) begin
          if (j > 0) @(negedge clk);
          if (rst) begin
            abort_f = 1'b1;
            break;
          end
          if (uart_txd !== eb[j / CPB]) mism++;
          if ((j % CPB) == CPB / 2 && (j / CPB) >= 1 && (j / CPB) <= 8)
            got[(j / CPB) - 1] = uart_txd;
        end
        if (!abort_f && have) begin
          chk("mon_bits", mism, 0);
          chk("mon_data", {24'd0, got}, {24'd0, d});
        end
        prev = abort_f ? 1'b1 : uart_txd;
      end else begin
        prev = uart_txd;
      end
    end
  end

  initial begin
    int cyc;
    int cnt;
    logic [7:0] bb [4];
    bb = '{8'h13, 8'h01, 8'h01, 8'hFD};
    rst = 1'b1;
    uart_tx_en = 1'b0;
    uart_tx_data = '0;
    #1;
    chk("reset_txd", uart_txd, 1);
    chk("reset_busy", uart_tx_busy, 0);
    chk("reset_done", uart_tx_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 0x55, exact frame length and single done pulse
    send(8'h55);
    chk("t1_busy_on", uart_tx_busy, 1);
    chk("t1_txd_start", uart_txd, 0);
    wait_idle(cyc);
    chk("t1_len", cyc, FRAME);
    chk("t1_done", uart_tx_done, 1);
    @(posedge clk); #1;
    chk("t1_done_pulse", uart_tx_done, 0);

    // en pulse while busy is ignored
    send(8'hA5);
    repeat (3 * CPB) begin @(posedge clk); #1; end
    @(negedge clk);
    uart_tx_en = 1'b1;
    uart_tx_data = 8'hFF;
    @(posedge clk); #1;
    uart_tx_en = 1'b0;
    chk("t2_busy_held", uart_tx_busy, 1);
    wait_idle(cyc);
    chk("t2_len", cyc + 3 * CPB + 1, FRAME);
    cnt = 0;
    repeat (3 * FRAME) begin
      @(posedge clk); #1;
      if (uart_tx_busy || !uart_txd) cnt++;
    end
    chk("t2_no_second", cnt, 0);

    // back-to-back frames, next accept in the done cycle
    send(bb[0]);
    for (int i = 1; i < 4; i++) begin
      wait_idle(cyc);
      chk("t3_len", cyc, FRAME);
      chk("t3_done", uart_tx_done, 1);
      accept_now(bb[i]);
      chk("t3_b2b_busy", uart_tx_busy, 1);
      chk("t3_b2b_start", uart_txd, 0);
    end
    wait_idle(cyc);
    chk("t3_last_len", cyc, FRAME);

    // reset during data bit 4 of 0xC3, then 0x3C intact
    send(8'hC3);
    repeat (5 * CPB + CPB / 2) @(posedge clk);
    #1;
    chk("t4_bit4", uart_txd, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_txd", uart_txd, 1);
    chk("t4_rst_busy", uart_tx_busy, 0);
    chk("t4_rst_done", uart_tx_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(8'h3C);
    wait_idle(cyc);
    chk("t4_len", cyc, FRAME);

`ifdef UART_TX_PARITY_EN
    // parity bit and 11-bit frame
    send(8'h07);
    repeat (9 * CPB + CPB / 2) begin @(posedge clk); #1; end
    chk("t5_par07", uart_txd, 1);
    wait_idle(cyc);
    chk("t5_len07", cyc + 9 * CPB + CPB / 2, 11 * CPB);
    send(8'h03);
    repeat (9 * CPB + CPB / 2) begin @(posedge clk); #1; end
    chk("t5_par03", uart_txd, 0);
    wait_idle(cyc);
    chk("t5_len03", cyc + 9 * CPB + CPB / 2, 11 * CPB);
`endif

    // rst and en together: nothing accepted
    @(negedge clk);
    rst = 1'b1;
    uart_tx_en = 1'b1;
    uart_tx_data = 8'h99;
    @(posedge clk); #1;
    chk("t6_busy", uart_tx_busy, 0);
    chk("t6_txd", uart_txd, 1);
    @(negedge clk);
    rst = 1'b0;
    uart_tx_en = 1'b0;
    cnt = 0;
    repeat (2 * FRAME) begin
      @(posedge clk); #1;
      if (uart_tx_busy || !uart_txd) cnt++;
    end
    chk("t6_no_frame", cnt, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
